pingpong_bram_buf: RTL
======================

// Module: pingpong_bram_buf
// PURPOSE
//  Two-bank (ping-pong) block-RAM buffer with one clock. A producer fills one bank while a
//  consumer reads the other; banks swap on commit/release handshakes. Generalises the fixed
//  32x256 dual-port BRAM with width, depth, byte enables, optional output register and frame-length tracking.
//  Sits between a packet/frame producer (e.g. link receiver) and a register/DMA reader.
// PARAMETERS
//  DATA_W   32  word width; multiple of 8
//  ADDR_W   8   address width per bank; bank depth = 2**ADDR_W words
//  OUT_REG  0   0: read latency 1 cycle; 1: extra output register, latency 2
//  BE_W     DATA_W/8  (localparam) byte-enable width
// PORTS
//  clk         in   1         single clock, all logic rising-edge
//  rst_n       in   1         asynchronous, active-low reset
//  wr_en       in   1         write strobe into current write bank
//  wr_be       in   BE_W      byte enables for wr_data lanes
//  wr_addr     in   ADDR_W    word address within write bank
//  wr_data     in   DATA_W    write data
//  wr_commit   in   1         close write bank; mark it full with length wr_len
//  wr_len      in   ADDR_W+1  valid word count of committed bank, 1..2**ADDR_W
//  wr_ready    out  1         a bank is free for writing
//  rd_en       in   1         read strobe from current read bank
//  rd_addr     in   ADDR_W    word address within read bank
//  rd_data     out  DATA_W    read data
//  rd_valid    out  1         rd_data valid this cycle
//  rd_avail    out  1         a committed bank is available to read
//  rd_len      out  ADDR_W+1  length of current read bank (0 when !rd_avail)
//  rd_release  in   1         consumer done with read bank; return it to writer
//  full_cnt    out  2         number of committed banks, 0..2
//  err_ovf     out  1         1-cycle pulse: wr_en/wr_commit while !wr_ready, or commit with wr_len==0 or >2**ADDR_W
//  err_udf     out  1         1-cycle pulse: rd_release while !rd_avail
// BEHAVIOUR
//  - State: wb (write bank idx), rb (read bank idx), full_cnt, len[0:1]. Reset: wb=rb=0,
//    full_cnt=0, len=0, rd_data=0, rd_valid=0, err_*=0. RAM contents not reset (undefined).
//  - wr_ready = (full_cnt!=2); rd_avail = (full_cnt!=0); rd_len = rd_avail ? len[rb] : 0.
//  - Write: wr_en & wr_ready -> mem[wb][wr_addr] lanes with wr_be=1 updated next edge; other lanes kept.
//    wr_en & !wr_ready -> dropped, err_ovf pulses next cycle.
//  - Commit: wr_commit & wr_ready & valid wr_len -> len[wb]<=wr_len, wb<=~wb, full_cnt+1.
//    A wr_en in the same cycle as commit still lands in the old wb (pre-toggle).
//    Invalid wr_len or !wr_ready -> no state change, err_ovf pulse.
//  - Release: rd_release & rd_avail -> rb<=~rb, full_cnt-1, len[rb] cleared. Else err_udf pulse.
//  - Simultaneous valid commit + release: both banks toggle, full_cnt unchanged.
//  - Collision-free by construction: full_cnt==1 -> wb!=rb; full_cnt==2 -> writes blocked;
//    full_cnt==0 -> reads blocked. No bypass logic required.
//  - Read: rd_en & rd_avail samples mem[rb][rd_addr] at edge N; OUT_REG=0 -> rd_data/rd_valid
//    at N+1; OUT_REG=1 -> at N+2. rd_en & !rd_avail ignored (no rd_valid). rd_en with
//    rd_release same cycle reads old rb. rd_addr>=rd_len is legal, returns stale data.
//  - rd_valid is a 1-cycle pulse per accepted read; rd_data holds last value when !rd_valid.
//  - rst_n assertion mid-frame discards all banks immediately (async), in-flight reads lost.
// TESTING
//  1 Reset: rst_n=0 any time -> wr_ready=1, rd_avail=0, full_cnt=0, rd_valid=0, rd_data=0.
//  2 Fill bank0 addr0..3 = 0x11..0x44, commit len=4 -> rd_avail=1, rd_len=4; read addr2 ->
//    rd_data=0x33 one cycle later (OUT_REG=0) / two cycles (OUT_REG=1), rd_valid single pulse.
//  3 Commit two banks (full_cnt=2), then wr_en -> err_ovf pulse, wr_ready=0, bank data unchanged;
//    release -> full_cnt=1, wr_ready=1, rd_len shows second bank's length.
//  4 Byte enables: write 0xAABBCCDD, then 0x11223344 with wr_be=4'b0101 -> read 0xAA22CC44.
//  5 Same-cycle commit+release at full_cnt=1 -> full_cnt stays 1, wb and rb both toggle, new
//    data readable; release at full_cnt=0 -> err_udf pulse, no state change.
//  6 Commit wr_len=0 -> err_ovf, full_cnt unchanged; async reset during reads -> rd_valid drops at once.

Source files
------------

// File: rtl/pingpong_bram_buf.sv
// Two-bank ping-pong block-RAM buffer: the producer fills one bank while the consumer
// reads the other, and the banks swap on commit/release handshakes.
module pingpong_bram_buf #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 8,
    parameter int OUT_REG = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_en,
    input  logic [DATA_W/8-1:0] wr_be,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic                wr_commit,
    input  logic [ADDR_W:0]     wr_len,
    output logic                wr_ready,
    input  logic                rd_en,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic [DATA_W-1:0]   rd_data,
    output logic                rd_valid,
    output logic                rd_avail,
    output logic [ADDR_W:0]     rd_len,
    input  logic                rd_release,
    output logic [1:0]          full_cnt,
    output logic                err_ovf,
    output logic                err_udf
);
    localparam int BE_W  = DATA_W / 8;
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};

    // Both banks share one array; the bank index is the top address bit.
    logic [DATA_W-1:0] mem [0:2*DEPTH-1];
    logic              wb;
    logic              rb;
    logic [ADDR_W:0]   len [0:1];

    logic len_ok;
    logic wr_ok;
    logic commit_ok;
    logic rel_ok;
    logic rd_ok;

    assign wr_ready  = (full_cnt != 2'd2);
    assign rd_avail  = (full_cnt != 2'd0);
    assign rd_len    = rd_avail ? len[rb] : '0;
    assign len_ok    = (wr_len != '0) && (wr_len <= MAX_LEN);
    assign wr_ok     = wr_en && wr_ready;
    assign commit_ok = wr_commit && wr_ready && len_ok;
    assign rel_ok    = rd_release && rd_avail;
    assign rd_ok     = rd_en && rd_avail;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb       <= 1'b0;
            rb       <= 1'b0;
            full_cnt <= 2'd0;
            len[0]   <= '0;
            len[1]   <= '0;
            err_ovf  <= 1'b0;
            err_udf  <= 1'b0;
        end else begin
            err_ovf <= (wr_en && !wr_ready) || (wr_commit && !(wr_ready && len_ok));
            err_udf <= rd_release && !rd_avail;
            // wb != rb whenever both handshakes succeed, so the two len updates never collide.
            if (rel_ok) begin
                len[rb] <= '0;
                rb      <= ~rb;
            end
            if (commit_ok) begin
                len[wb] <= wr_len;
                wb      <= ~wb;
            end
            case ({commit_ok, rel_ok})
                2'b10:   full_cnt <= full_cnt + 2'd1;
                2'b01:   full_cnt <= full_cnt - 2'd1;
                default: full_cnt <= full_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            for (int b = 0; b < BE_W; b++) begin
                if (wr_be[b]) mem[{wb, wr_addr}][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
    end

    generate
        if (OUT_REG == 0) begin : g_lat1
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rd_valid <= 1'b0;
                    rd_data  <= '0;
                end else begin
                    rd_valid <= rd_ok;
                    if (rd_ok) rd_data <= mem[{rb, rd_addr}];
                end
            end
        end else begin : g_lat2
            logic [DATA_W-1:0] rd_word_p0;
            logic              vld_p0;

            // Stage p0: raw RAM read
            always_ff @(posedge clk) begin
                if (rd_ok) rd_word_p0 <= mem[{rb, rd_addr}];
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld_p0   <= 1'b0;
                    rd_valid <= 1'b0;
                    rd_data  <= '0;
                end else begin
                    vld_p0   <= rd_ok;
                    // Stage p1: output register
                    rd_valid <= vld_p0;
                    if (vld_p0) rd_data <= rd_word_p0;
                end
            end
        end
    endgenerate
endmodule
